// File: rtl/bram_64_rd_stream.sv
// Streaming reader for port B of the 512 x 64 block RAM: fetches a run of words and
// serialises each one MSB-byte-first onto a valid/ready byte stream.
module bram_64_rd_stream #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OUT_W  = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [ADDR_W:0]   len_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              bram_en_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  input  logic [DATA_W-1:0] bram_rd_d_in,
  output logic [OUT_W-1:0]  data_out,
  output logic              valid_out,
  input  logic              ready_in
);

  localparam int unsigned Beats = DATA_W / OUT_W;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [ADDR_W:0]   CntZero  = '0;
  localparam logic [ADDR_W:0]   CntOne   = 1;
  localparam logic [ADDR_W-1:0] AddrOne  = 1;
  localparam logic [BeatW-1:0]  BeatOne  = 1;
  localparam logic [BeatW-1:0]  LastBeat = BeatW'(Beats - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   fetch_cnt_q, fetch_cnt_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic              pf_valid_q, pf_valid_d;
  logic [DATA_W-1:0] pf_data_q, pf_data_d;
  logic              sr_valid_q, sr_valid_d;
  logic [DATA_W-1:0] sr_data_q, sr_data_d;
  logic [BeatW-1:0]  beat_q, beat_d;

  logic fetch_go;
  logic xfer;
  logic word_end;
  logic sr_free;
  logic final_beat;

  // One read at a time, and only into an empty prefetch slot, so a returning
  // word always has somewhere to land.
  assign fetch_go   = (state_q == StRun) && (fetch_cnt_q != CntZero) &&
                      !inflight_q && !pf_valid_q;
  assign xfer       = sr_valid_q && ready_in;
  assign word_end   = xfer && (beat_q == LastBeat);
  assign sr_free    = !sr_valid_q || word_end;
  assign final_beat = word_end && (fetch_cnt_q == CntZero) && !inflight_q && !pf_valid_q;

  assign busy_out      = (state_q == StRun);
  assign done_out      = done_q;
  assign bram_en_out   = fetch_go;
  assign bram_addr_out = addr_q;
  assign valid_out     = sr_valid_q;
  assign data_out      = sr_data_q[DATA_W-1 -: OUT_W];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fetch_cnt_d = fetch_cnt_q;
    inflight_d  = fetch_go;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          if (len_in != CntZero) begin
            addr_d      = base_addr_in;
            fetch_cnt_d = len_in;
            state_d     = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (fetch_go) begin
          addr_d      = addr_q + AddrOne;
          fetch_cnt_d = fetch_cnt_q - CntOne;
        end
        if (final_beat) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    sr_valid_d = sr_valid_q;
    sr_data_d  = sr_data_q;
    beat_d     = beat_q;
    pf_valid_d = pf_valid_q;
    pf_data_d  = pf_data_q;
    if (xfer) begin
      sr_data_d = sr_data_q << OUT_W;
      beat_d    = beat_q + BeatOne;
    end
    if (word_end) begin
      beat_d = '0;
      if (pf_valid_q) begin
        sr_data_d  = pf_data_q;
        sr_valid_d = 1'b1;
        pf_valid_d = 1'b0;
      end else begin
        sr_valid_d = 1'b0;
      end
    end
    // A read is only issued with the prefetch slot empty, so capture never
    // collides with the prefetch-to-shift reload above.
    if (inflight_q) begin
      if (sr_free) begin
        sr_data_d  = bram_rd_d_in;
        sr_valid_d = 1'b1;
        beat_d     = '0;
      end else begin
        pf_data_d  = bram_rd_d_in;
        pf_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      fetch_cnt_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      pf_valid_q  <= 1'b0;
      pf_data_q   <= '0;
      sr_valid_q  <= 1'b0;
      sr_data_q   <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fetch_cnt_q <= fetch_cnt_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      pf_valid_q  <= pf_valid_d;
      pf_data_q   <= pf_data_d;
      sr_valid_q  <= sr_valid_d;
      sr_data_q   <= sr_data_d;
      beat_q      <= beat_d;
    end
  end

endmodule

// File: doc/bram_64_rd_stream.md
Name: bram_64_rd_stream

Overview:
- Reader side of the 512 x 64 dual-port block RAM; connects to the RAM's read-only port B.
- On a start command, fetches a run of 64-bit words from a base address.
- Serialises each word MSB-byte-first onto an 8-bit valid/ready byte stream for the network/pixel output path.
- Hides the RAM's 1-cycle read latency with a one-word prefetch register, so output runs at 1 byte/cycle after the first word.

Parameters:
ADDR_W, 9, RAM word-address width (512 words)
DATA_W, 64, RAM word width; must be a multiple of OUT_W
OUT_W, 8, output stream width (DATA_W/OUT_W = 8 beats per word)

Ports:
clk_in  input  1  single clock; RAM port B shares this clock
rst_in  input  1  synchronous, active-high reset
start_in  input  1  begin run; sampled only when busy_out=0
base_addr_in  input  ADDR_W  first word address, latched on start
len_in  input  ADDR_W+1  run length in words, 0..512, latched on start
busy_out  output  1  run in progress
done_out  output  1  one-cycle pulse after last byte accepted
bram_en_out  output  1  RAM port B enable (read strobe); port B write enables tied 0 externally
bram_addr_out  output  ADDR_W  RAM port B address
bram_rd_d_in  input  DATA_W  RAM port B read data, valid the cycle after bram_en_out
data_out  output  OUT_W  stream byte
valid_out  output  1  data_out valid
ready_in  input  1  downstream accepts; a beat transfers when valid_out && ready_in

Behaviour:
- Reset: all outputs 0, state IDLE, counters and both buffer-valid flags cleared. Reset mid-run abandons the run: no done_out, no further RAM reads.
- States:
  - IDLE:
    - start_in=1 with len_in!=0: latch addr and remaining-words count = len_in; busy_out=1 next cycle; go RUN.
    - start_in=1 with len_in=0: stay IDLE, pulse done_out next cycle, busy_out stays 0.
  - RUN: fetch/shift engine below; leaves to DONE when the final byte of the final word transfers.
  - DONE: done_out=1 and busy_out=0 for exactly one cycle, then IDLE. start_in is ignored in DONE and whenever busy_out=1.
- Fetch:
  - Issue a read (bram_en_out=1 for one cycle, bram_addr_out=current addr) when words-remaining-to-fetch>0, no read is in flight, and the prefetch register is empty.
  - On issue: addr increments modulo 2^ADDR_W (wraps 511->0); fetch count decrements.
  - The cycle after issue, bram_rd_d_in is captured into the shift register if it is empty or is being emptied this cycle; otherwise into the prefetch register.
  - bram_en_out=0 at all other times.
- Timing: start sampled at cycle T -> bram_en_out=1 with addr=base at T+1 -> data captured at end of T+2 -> valid_out=1 with bits [63:56] at T+3.
- Shift:
  - Beat order per word: [63:56], [55:48], ..., [7:0].
  - Beat counter 0..7 advances only on transfer.
  - On the 8th transfer of a word, the shift register reloads from prefetch in the same edge if prefetch is valid, giving no bubble. Otherwise valid_out drops until the next capture.
- Handshake:
  - While valid_out=1 and ready_in=0, data_out and valid_out hold stable.
  - valid_out never depends combinationally on ready_in.
- Throughput: with ready_in held 1, a run of N words produces 8N consecutive beats starting at T+3; last beat at T+2+8N; done_out at T+3+8N.
- len_in=512 reads every word exactly once, including wrap when base!=0.

Test Plan:
- Reset, then start base=0x010, len=1, RAM[0x010]=0x0123456789ABCDEF, ready=1 -> bram_en at T+1 addr 0x010; bytes 01,23,45,67,89,AB,CD,EF on T+3..T+10; done_out at T+11 only.
- Start base=0x1FE, len=4, ready=1 -> reads 0x1FE,0x1FF,0x000,0x001; 32 contiguous beats with no valid gap; done at T+35.
- Same run with ready_in toggling 1,0,0,1 repeating -> byte sequence identical; data_out stable during every stall; bram_en asserted exactly 4 times; no beat lost or duplicated.
- Start len=0 -> no bram_en, no valid_out; done_out pulses once; busy_out stays 0.
- start_in pulsed while busy with different base -> ignored; original run completes unchanged.
- rst_in asserted mid-run after 11 beats -> next cycle all outputs 0; no done_out; a fresh start afterwards behaves as the first scenario.
